// File: rtl/fitter_scalar_n.sv
// Track-fit scalar-product engine: per-channel sum of coefficient x hit plus offset,
// scaled and saturated, presented with per-channel clip flags and a one-cycle READY.
module fitter_scalar_n_lane #(
    parameter int CW    = 14,
    parameter int HW    = 15,
    parameter int AW    = 34,
    parameter int OW    = 14,
    parameter int SHIFT = 0
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          i_s0_vld,
    input  logic          i_accept,
    input  logic          i_ev,
    input  logic [HW-1:0] i_hin,
    input  logic [CW-1:0] i_cin,
    input  logic [CW-1:0] i_c0,
    input  logic          i_vld1,
    input  logic          i_first1,
    input  logic          i_last1,
    input  logic          i_vld2,
    input  logic          i_vld3,
    output logic [OW-1:0] o_out,
    output logic          o_of
);
    localparam int PW = CW + HW;
    localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [PW-1:0] r_p;
    logic signed [CW-1:0] r_c0;
    logic signed [AW-1:0] r_acc, r_sum, r_sh;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_p_ext, w_c0_ext, w_acc_nxt;
    logic                 w_hi, w_lo;

    assign w_prod    = $signed(i_cin) * $signed(i_hin);
    assign w_p_ext   = {{(AW-PW){r_p[PW-1]}}, r_p};
    assign w_c0_ext  = {{(AW-CW){r_c0[CW-1]}}, r_c0};
    assign w_acc_nxt = (i_first1 ? '0 : r_acc) + w_p_ext;
    assign w_hi      = (r_sh > MAXV);
    assign w_lo      = (r_sh < MINV);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_p   <= '0;
            r_c0  <= '0;
            r_acc <= '0;
            r_sum <= '0;
            r_sh  <= '0;
            o_out <= '0;
            o_of  <= 1'b0;
        end else begin
            // EV without an accepted word still enters the pipe, carrying P=0
            if (i_s0_vld) begin
                r_p <= i_accept ? w_prod : '0;
                if (i_ev) r_c0 <= i_c0;
            end
            if (i_vld1) begin
                r_acc <= w_acc_nxt;
                if (i_last1) r_sum <= w_acc_nxt + w_c0_ext;
            end
            if (i_vld2) r_sh <= r_sum >>> SHIFT;
            if (i_vld3) begin
                o_out <= w_hi ? MAXV[OW-1:0] : (w_lo ? MINV[OW-1:0] : r_sh[OW-1:0]);
                o_of  <= w_hi | w_lo;
            end
        end
    end
endmodule

module fitter_scalar_n #(
    parameter int NCH    = 5,
    parameter int CW     = 14,
    parameter int HW     = 15,
    parameter int AW     = 34,
    parameter int OW     = 14,
    parameter int SHIFT  = 0,
    parameter int MAXHIT = 16
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               DV,
    input  logic               EV,
    input  logic [HW-1:0]      HIN,
    input  logic [NCH*CW-1:0]  CIN,
    input  logic [NCH*CW-1:0]  C0IN,
    output logic [NCH*OW-1:0]  OUT,
    output logic [NCH-1:0]     OF,
    output logic               READY,
    output logic               ERR,
    output logic [1:0]         state_out
);
    localparam int CNTW = $clog2(MAXHIT + 2);
    localparam logic [CNTW-1:0] CMAX = CNTW'(MAXHIT);
    localparam logic [CNTW-1:0] COVF = CNTW'(MAXHIT + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, ACC = 2'b01, BAD = 2'b10, DROP = 2'b11} state_t;

    state_t          r_state;
    logic [CNTW-1:0] r_cnt;
    logic            r_start;
    logic [4:1]      r_vld_pipe;
    logic            r_first1, r_last1, r_err1, r_err2, r_err3, r_err_o;
    logic            w_accept, w_s0_vld, w_ovf;

    assign w_accept  = DV && (r_cnt < CMAX);
    assign w_s0_vld  = w_accept || EV;
    // Track is flagged if it carried more than MAXHIT words, including a DV on the EV cycle
    assign w_ovf     = (r_cnt == COVF) || (DV && (r_cnt == CMAX));
    assign READY     = r_vld_pipe[4];
    assign ERR       = r_err_o;
    assign state_out = r_state;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_start    <= 1'b1;
            r_vld_pipe <= '0;
            r_first1   <= 1'b0;
            r_last1    <= 1'b0;
            r_err1     <= 1'b0;
            r_err2     <= 1'b0;
            r_err3     <= 1'b0;
            r_err_o    <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (DV && !EV) r_state <= ACC;
                ACC:     if (EV) r_state <= IDLE;
                         else if (DV && (r_cnt == CMAX)) r_state <= DROP;
                DROP:    if (EV) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (EV)                         r_cnt <= '0;
            else if (DV && (r_cnt != COVF)) r_cnt <= r_cnt + 1'b1;

            if (EV)            r_start <= 1'b1;
            else if (w_accept) r_start <= 1'b0;

            r_vld_pipe[1] <= w_s0_vld;
            r_first1      <= r_start;
            r_last1       <= EV;
            r_err1        <= EV && w_ovf;

            r_vld_pipe[2] <= r_vld_pipe[1] && r_last1;
            r_err2        <= r_err1;
            r_vld_pipe[3] <= r_vld_pipe[2];
            r_err3        <= r_err2;
            r_vld_pipe[4] <= r_vld_pipe[3];
            if (r_vld_pipe[3]) r_err_o <= r_err3;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        fitter_scalar_n_lane #(
            .CW(CW), .HW(HW), .AW(AW), .OW(OW), .SHIFT(SHIFT)
        ) u_lane (
            .CLOCK    (CLOCK),
            .RESET    (RESET),
            .i_s0_vld (w_s0_vld),
            .i_accept (w_accept),
            .i_ev     (EV),
            .i_hin    (HIN),
            .i_cin    (CIN[g*CW +: CW]),
            .i_c0     (C0IN[g*CW +: CW]),
            .i_vld1   (r_vld_pipe[1]),
            .i_first1 (r_first1),
            .i_last1  (r_last1),
            .i_vld2   (r_vld_pipe[2]),
            .i_vld3   (r_vld_pipe[3]),
            .o_out    (OUT[g*OW +: OW]),
            .o_of     (OF[g])
        );
    end
endmodule

// File: tb/tb_fitter_scalar_n.sv
// Scoreboard bench for fitter_scalar_n: a track-level model pushes expected results on EV,
// a negedge monitor pops and compares on every READY.
module tb_fitter_scalar_n;
    localparam int NCH = 5, CW = 14, HW = 15, AW = 34, OW = 14, SHIFT = 0, MAXHIT = 16;

    logic              CLOCK = 1'b0;
    logic              RESET, DV, EV;
    logic [HW-1:0]     HIN;
    logic [NCH*CW-1:0] CIN, C0IN;
    logic [NCH*OW-1:0] OUT;
    logic [NCH-1:0]    OF;
    logic              READY, ERR;
    logic [1:0]        state_out;

    fitter_scalar_n #(.NCH(NCH), .CW(CW), .HW(HW), .AW(AW), .OW(OW), .SHIFT(SHIFT), .MAXHIT(MAXHIT)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .DV(DV), .EV(EV), .HIN(HIN), .CIN(CIN), .C0IN(C0IN),
        .OUT(OUT), .OF(OF), .READY(READY), .ERR(ERR), .state_out(state_out));

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [NCH*OW-1:0] out;
        logic [NCH-1:0]    of;
        logic              err;
        int                due;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0, failures = 0, cyc_cnt = 0;
    int                m_n = 0;
    int                m_h[$];
    logic [NCH*CW-1:0] m_c[$];
    logic [NCH*OW-1:0] l_out = '0;
    logic [NCH-1:0]    l_of = '0;
    logic              l_err = 1'b0;

    always @(posedge CLOCK) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    // Outputs must hold between READY pulses and reset back to zero
    always @(posedge CLOCK) if (RESET) begin l_out = '0; l_of = '0; l_err = 1'b0; end

    always @(negedge CLOCK) begin
        if (!RESET) begin
            if (READY) begin
                if (sb.size() == 0) begin
                    chk("ready_unexpected", 80'(READY), 80'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ready_time", 80'(cyc_cnt), 80'(e.due));
                    chk("out", 80'(OUT), 80'(e.out));
                    chk("of", 80'(OF), 80'(e.of));
                    chk("err", 80'(ERR), 80'(e.err));
                    l_out = e.out; l_of = e.of; l_err = e.err;
                end
            end else begin
                chk("hold", {OUT, OF, ERR}, {l_out, l_of, l_err});
            end
        end
    end

    function automatic logic [NCH*CW-1:0] rep(input logic [CW-1:0] v);
        logic [NCH*CW-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*CW +: CW] = v;
        return r;
    endfunction

    task automatic model_ev(input logic [NCH*CW-1:0] c0);
        exp_t   e;
        longint s, lim;
        lim = longint'(1) <<< (OW - 1);
        e.err = (m_n > MAXHIT);
        for (int ch = 0; ch < NCH; ch++) begin
            logic [CW-1:0] c0v;
            c0v = c0[ch*CW +: CW];
            s = longint'($signed(c0v));
            for (int w = 0; w < m_h.size(); w++) begin
                logic [NCH*CW-1:0] cw;
                logic [CW-1:0]     cv;
                cw = m_c[w];
                cv = cw[ch*CW +: CW];
                s += longint'($signed(cv)) * longint'(m_h[w]);
            end
            s = s >>> SHIFT;
            e.of[ch] = (s >= lim) || (s < -lim);
            if (s >= lim) s = lim - 1;
            else if (s < -lim) s = -lim;
            e.out[ch*OW +: OW] = s[OW-1:0];
        end
        e.due = cyc_cnt + 3;
        sb.push_back(e);
        m_n = 0;
        m_h.delete();
        m_c.delete();
    endtask

    task automatic cyc(input logic dv, input logic ev, input logic [HW-1:0] h,
                       input logic [NCH*CW-1:0] c, input logic [NCH*CW-1:0] c0);
        DV = dv; EV = ev; HIN = h; CIN = c; C0IN = c0;
        @(posedge CLOCK);
        #1;
        if (dv) begin
            m_n++;
            if (m_n <= MAXHIT) begin m_h.push_back(int'($signed(h))); m_c.push_back(c); end
        end
        if (ev) model_ev(c0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0);
    endtask

    function automatic logic [HW-1:0] rnd_h();
        case ($urandom_range(0, 7))
            0:       return 15'h3FFF;
            1:       return 15'h4000;
            2, 3:    return HW'($urandom_range(0, 100) - 50);
            default: return HW'($urandom);
        endcase
    endfunction

    function automatic logic [NCH*CW-1:0] rnd_c();
        logic [NCH*CW-1:0] r;
        for (int i = 0; i < NCH; i++)
            case ($urandom_range(0, 5))
                0:       r[i*CW +: CW] = 14'h1FFF;
                1:       r[i*CW +: CW] = 14'h2000;
                2, 3:    r[i*CW +: CW] = CW'($urandom_range(0, 40) - 20);
                default: r[i*CW +: CW] = CW'($urandom);
            endcase
        return r;
    endfunction

    initial begin
        logic [NCH*CW-1:0] cv, c0v;
        RESET = 1'b1; DV = 1'b0; EV = 1'b0; HIN = '0; CIN = '0; C0IN = '0;
        for (int i = 0; i < 3; i++) begin
            DV = i[0]; HIN = 15'd7; CIN = rep(14'd3);
            @(posedge CLOCK); #1;
        end
        chk("rst_out", 80'(OUT), 80'(0));
        chk("rst_of", 80'(OF), 80'(0));
        chk("rst_err_ready", 80'({ERR, READY}), 80'(0));
        chk("rst_state", 80'(state_out), 80'(0));
        RESET = 1'b0;
        idle(2);

        // three-word track
        cyc(1'b1, 1'b0, 15'd1, rep(14'd1), '0);
        chk("state_acc", 80'(state_out), 80'(1));
        cyc(1'b1, 1'b0, 15'd1, rep(14'd1), '0);
        cyc(1'b1, 1'b1, 15'd1, rep(14'd1), '0);
        chk("state_idle", 80'(state_out), 80'(0));
        idle(5);

        // offset and sign
        cv = '0; cv[CW-1:0] = 14'd100;
        c0v = '0; c0v[CW-1:0] = 14'd5;
        cyc(1'b1, 1'b1, -15'sd2, cv, c0v);
        idle(5);

        // saturation both ways
        cyc(1'b1, 1'b1, 15'd16383, rep(14'd8191), '0);
        cyc(1'b1, 1'b1, 15'h4000, rep(14'd8191), '0);
        idle(5);

        // back-to-back one-word tracks
        cyc(1'b1, 1'b1, 15'd1, rep(14'd2), '0);
        cyc(1'b1, 1'b1, 15'd3, rep(14'd2), '0);
        idle(5);

        // EV-only track gives the offset
        cyc(1'b0, 1'b1, '0, '0, rep(14'h3FF0));
        idle(5);

        // word-count overflow
        for (int i = 0; i < MAXHIT + 1; i++) cyc(1'b1, 1'b0, rnd_h(), rnd_c(), '0);
        chk("state_drop", 80'(state_out), 80'(3));
        cyc(1'b0, 1'b1, '0, '0, rnd_c());
        idle(5);

        // reset mid-track discards it
        cyc(1'b1, 1'b0, 15'd9, rep(14'd9), '0);
        cyc(1'b1, 1'b0, 15'd9, rep(14'd9), '0);
        RESET = 1'b1; DV = 1'b0; EV = 1'b0;
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        m_n = 0; m_h.delete(); m_c.delete();
        chk("rst_mid_state", 80'(state_out), 80'(0));
        chk("rst_mid_out", 80'({OUT, OF, ERR, READY}), 80'(0));
        cyc(1'b1, 1'b1, 15'd4, rep(14'd5), rep(14'd1));
        idle(5);

        // randomized tracks with gaps
        for (int t = 0; t < 40; t++) begin
            int n;
            bit ev_last;
            n = $urandom_range(0, 20);
            ev_last = (n > 0) && ($urandom_range(0, 1) == 1);
            for (int w = 0; w < n; w++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                if (ev_last && (w == n - 1)) cyc(1'b1, 1'b1, rnd_h(), rnd_c(), rnd_c());
                else                        cyc(1'b1, 1'b0, rnd_h(), rnd_c(), '0);
            end
            if (!ev_last) cyc(1'b0, 1'b1, '0, '0, rnd_c());
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        idle(8);
        chk("sb_drained", 80'(sb.size()), 80'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fitter_scalar_n.md
# fitter_scalar_n

Parametrised track-fit scalar-product engine for the GigaFitter mezzanine. It generalises the fixed five-output fitter to NCH fit parameters (chi components, phi, d, c, …) with configurable widths. For each hit word strobed by DV it accumulates coefficient × hit per channel, and on EV it adds a per-channel offset. It then scales, saturates and presents all NCH results with per-channel overflow flags and a one-cycle READY. It is fully pipelined, so a new track may start on the cycle after EV.

## Interface
Parameters:
- NCH, 5, number of fit-parameter channels
- CW, 14, signed coefficient and offset width
- HW, 15, signed hit-word width
- AW, 34, signed accumulator width; must be ≥ CW+HW+clog2(MAXHIT)
- OW, 14, signed output width
- SHIFT, 0, arithmetic right shift applied before saturation
- MAXHIT, 16, maximum hit words per track

Ports:
- CLOCK  in  1  single clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- DV  in  1  hit word valid; samples HIN and CIN
- EV  in  1  end of track; may coincide with DV, which then carries the last word
- HIN  in  HW  signed hit word
- CIN  in  NCH*CW  signed coefficients for the current word; channel i occupies [i*CW +: CW]
- C0IN  in  NCH*CW  signed per-channel offsets, sampled on the EV cycle
- OUT  out  NCH*OW  signed saturated results; channel i occupies [i*OW +: OW]
- OF  out  NCH  per-channel saturation flag
- READY  out  1  one-cycle pulse; OUT, OF and ERR are valid in this cycle
- ERR  out  1  word-count overflow flag for the track being presented
- state_out  out  2  input-side state

## Operation
- Input FSM, encoded on state_out:
  - IDLE=00 → ACC=01 on DV without EV.
  - ACC → DROP=11 when the (MAXHIT+1)-th DV arrives.
  - Any state → IDLE on EV.
  - 10 is unused; if reached, the FSM returns to IDLE.
- Word counter:
  - Cleared on EV.
  - Saturates at MAXHIT+1.
  - In DROP, DV words are ignored: no accumulation.
- Stage 1: per channel, P_i = CIN_i × HIN (signed, CW+HW bits), registered with tags {valid, last, first}.
- Stage 2: per channel, ACC_i = (first ? 0 : ACC_i) + P_i.
  - On last, the result is ACC_i + sign-extended C0_i; C0 is registered alongside the last tag.
  - EV without DV produces last with P=0. A track with zero words therefore gives C0.
- Stage 3 (output register):
  - R = sum >>> SHIFT (floor toward −∞).
  - Saturate R to [−2^(OW−1), 2^(OW−1)−1].
  - OF_i = 1 iff channel i clipped.
  - ERR = 1 iff the track reached DROP.
- OUT, OF and ERR hold until the next READY.
- The accumulator does not saturate internally; the AW sizing rule guarantees no wrap.

## Timing
- EV (with or without DV) sampled at edge k:
  - READY is high in the cycle after edge k+3, for exactly one cycle.
  - OUT, OF and ERR update on that same edge.
- Throughput: one word per cycle.
- Back-to-back tracks:
  - DV of a new track is accepted at edge k+1.
  - Consecutive EVs at edges k and k+1 give READY pulses in consecutive cycles.
- DV and EV together on the first word of a track form a one-word track.
- RESET:
  - Clears the pipeline, the accumulators and the counter.
  - OUT=0, OF=0, ERR=0, READY=0, state_out=00.
  - An in-flight track never produces READY.
  - Takes effect on the edge where RESET is high, including mid-track.

## Test plan
Parameters for all scenarios: NCH=5, CW=14, HW=15, OW=14, SHIFT=0.
1. **Reset.** Apply RESET for 3 cycles with DV toggling → all outputs 0, state_out=00, no READY.
2. **Three-word track.** Three DV words, HIN=1, all CIN=1, C0IN=0, EV on the third word → READY 3 edges after EV; every channel OUT=3, OF=0, ERR=0; state_out goes 01 then 00.
3. **Offset and sign.** Single DV+EV word, HIN=−2, CIN ch0=100, C0IN ch0=5, other channels 0 → OUT0=−195 (0x3F3D); other OUT=0.
4. **Saturation.**
   - HIN=16383, CIN=8191 → OUT=0x1FFF, OF=all 1s.
   - HIN=−16384, CIN=8191 → OUT=0x2000, OF set.
5. **Back-to-back tracks.** One-word track (HIN=1, CIN=2) with EV at edge k, then one-word track (HIN=3, CIN=2) with EV at edge k+1 → READY in two consecutive cycles, OUT=2 then 6.
6. **Count overflow and reset.**
   - 17 DV words, then EV → state_out=11 after the 17th word; READY with ERR=1; result covers the first 16 words only.
   - RESET after 2 words of a new track → no READY; the next track starts clean.
